nbcac_11di_seq_encoder: RTL

Multi-cycle, area-reduced NBCAC encoder for 11-bit data words producing 16-bit crosstalk-avoidance codewords. It maps each input to the same codeword as the combinational 11-bit NBCAC encoder core, but time-shares a single compare/subtract stage across all 16 weights. A sequencing FSM drives that stage, and valid/ready handshakes sit on both sides. It sits between a data source and the bus driver on links where area matters more than throughput.

---
 rtl/nbcac_11di_seq_encoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/nbcac_11di_seq_encoder.sv
// Multi-cycle 11-bit -> 16-bit NBCAC encoder. One shared compare/subtract stage
// resolves one codeword bit per clock, with valid/ready handshakes on both sides.
module nbcac_11di_seq_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_code,
    output logic        busy
);

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SUM_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Weight s_k by stage index; index 0 is stage 16 (the 4-bit index wraps after 15).
    function automatic logic [DATA_W-1:0] weight(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] w;
        case (idx)
            4'd1:    w = DATA_W'(1);
            4'd2:    w = DATA_W'(1220);
            4'd3:    w = DATA_W'(754);
            4'd4:    w = DATA_W'(466);
            4'd5:    w = DATA_W'(288);
            4'd6:    w = DATA_W'(178);
            4'd7:    w = DATA_W'(110);
            4'd8:    w = DATA_W'(68);
            4'd9:    w = DATA_W'(42);
            4'd10:   w = DATA_W'(26);
            4'd11:   w = DATA_W'(16);
            4'd12:   w = DATA_W'(10);
            4'd13:   w = DATA_W'(6);
            4'd14:   w = DATA_W'(4);
            default: w = DATA_W'(2);
        endcase
        return w;
    endfunction

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0]   r_q, r_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                prev_q, prev_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic                accept_c;
    logic [DATA_W-1:0]   s_cur_c;
    logic [DATA_W-1:0]   s_nxt_c;
    logic [SUM_W-1:0]    thr_c;
    logic                d_bit_c;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_c  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign busy      = busy_q;

    // Shared compare stage: threshold s_k + s_{k+1} in 12 bits, hysteresis band keeps prev.
    always_comb begin
        s_cur_c = weight(k_q);
        s_nxt_c = weight(k_q + IDX_W'(1));
        thr_c   = SUM_W'(s_cur_c) + SUM_W'(s_nxt_c);
        d_bit_c = prev_q;
        if (k_q == '0) begin
            d_bit_c = (r_q != '0);
        end else if (SUM_W'(r_q) >= thr_c) begin
            d_bit_c = 1'b1;
        end else if (r_q < s_cur_c) begin
            d_bit_c = 1'b0;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        r_d        = r_q;
        code_d     = code_q;
        prev_d     = prev_q;
        out_code_d = out_code_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                code_d[k_q - IDX_W'(1)] = d_bit_c;
                prev_d = d_bit_c;
                r_d    = r_q - (d_bit_c ? s_cur_c : DATA_W'(0));
                k_d    = k_q + IDX_W'(1);
                if (k_q == '0) begin
                    state_d    = ST_DONE;
                    k_d        = IDX_W'(2);
                    out_code_d = code_d;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = accept_c ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new word seeds d1 directly; the remaining residual is always even.
        if (accept_c) begin
            code_d = {{(CODE_W-1){1'b0}}, in_data[0]};
            prev_d = in_data[0];
            r_d    = in_data - {{(DATA_W-1){1'b0}}, in_data[0]};
            k_d    = IDX_W'(2);
        end

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= IDX_W'(2);
            r_q         <= '0;
            code_q      <= '0;
            prev_q      <= 1'b0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            r_q         <= r_d;
            code_q      <= code_d;
            prev_q      <= prev_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
